// File: rtl/rng_share_arbiter.sv
// Round-robin sharing of one raw random source among N_REQ requesters.
// The winner's captured word is reduced modulo its range by a bit-serial restoring divider.
module rng_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int RAW_W = 16,
  parameter int OUT_W = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RAW_W-1:0]       rnd_in,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*OUT_W-1:0] max_flat,
  output logic [N_REQ-1:0]       gnt,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       out_value,
  output logic [2:0]             out_id,
  output logic                   busy
);

  localparam int CNT_W = $clog2(RAW_W + 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [2:0]       id;
  logic [2:0]       win_id;
  logic             win_any;
  logic [RAW_W-1:0] raw;
  logic [OUT_W-1:0] div;
  logic [OUT_W:0]   rem;
  logic [OUT_W:0]   rem_next;
  logic [OUT_W+1:0] trial;
  logic [OUT_W+1:0] div_ext;
  logic [OUT_W-1:0] final_value;
  logic [CNT_W-1:0] cnt;

  // Scan from the farthest offset back to ptr so the nearest requester at or after ptr wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    win_any = |req;
    win_id  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (j == (int'(ptr) + i) % N_REQ && req[j]) win_id = 3'(j);
      end
    end
  end

  // One restoring step; rem carries an extra bit because a zero divisor lets it grow unchecked.
  always_comb begin
    trial       = {rem, raw[RAW_W-1]};
    div_ext     = {2'b00, div};
    rem_next    = (trial >= div_ext) ? (OUT_W+1)'(trial - div_ext) : trial[OUT_W:0];
    final_value = (div == '0) ? '0 : rem_next[OUT_W-1:0];
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      id        <= '0;
      raw       <= '0;
      div       <= '0;
      rem       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
      out_value <= '0;
      out_id    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            id    <= win_id;
            raw   <= rnd_in;
            div   <= max_flat[int'(win_id)*OUT_W +: OUT_W];
            rem   <= '0;
            cnt   <= CNT_W'(RAW_W);
            busy  <= 1'b1;
            state <= DIV;
          end
        end
        DIV: begin
          rem <= rem_next;
          raw <= {raw[RAW_W-2:0], 1'b0};
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            out_valid <= 1'b1;
            gnt       <= N_REQ'(1) << id;
            out_value <= final_value;
            out_id    <= id;
            state     <= DONE;
          end
        end
        DONE: begin
          out_valid <= 1'b0;
          gnt       <= '0;
          busy      <= 1'b0;
          ptr       <= (int'(id) == N_REQ - 1) ? 3'd0 : id + 3'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_share_arbiter.sv
// Directed bench for rng_share_arbiter: a driver queues expected grants,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_rng_share_arbiter;

  localparam int N_REQ = 4;
  localparam int RAW_W = 16;
  localparam int OUT_W = 9;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [RAW_W-1:0]       rnd_in;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*OUT_W-1:0] max_flat;
  logic [N_REQ-1:0]       gnt;
  logic                   out_valid;
  logic [OUT_W-1:0]       out_value;
  logic [2:0]             out_id;
  logic                   busy;

  typedef struct {
    int gnt;
    int value;
    int id;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  rng_share_arbiter #(.N_REQ(N_REQ), .RAW_W(RAW_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .rnd_in    (rnd_in),
    .req       (req),
    .max_flat  (max_flat),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_value (out_value),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expect_grant(input int id, input int value, input int at_cyc);
    exp_t e;
    e.gnt   = 1 << id;
    e.value = value;
    e.id    = id;
    e.cyc   = at_cyc;
    sb_q.push_back(e);
  endtask

  task automatic set_max(input int k, input int val);
    max_flat[k*OUT_W +: OUT_W] = OUT_W'(val);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb_q.size(), 0);
    sb_q.delete();
  endtask

  // Monitor: every out_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", int'(out_valid), 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("gnt",       int'(gnt),       e.gnt);
          check("out_value", int'(out_value), e.value);
          check("out_id",    int'(out_id),    e.id);
          check("grant_cyc", cyc,             e.cyc);
        end
      end else if (gnt != '0) begin
        check("gnt_without_valid", int'(gnt), 0);
      end
    end
  end

  initial begin
    int c;
    reset    = 1'b1;
    req      = '0;
    max_flat = '0;
    rnd_in   = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt",       int'(gnt),       0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_value", int'(out_value), 0);
    check("rst_out_id",    int'(out_id),    0);
    check("rst_busy",      int'(busy),      0);
    reset = 1'b0;
    @(negedge clk);

    // Test 1: 0x0123 mod 10 = 1, grant 17 edges after the drive point.
    set_max(0, 10);
    rnd_in = 16'h0123;
    req    = 4'b0001;
    c      = cyc;
    expect_grant(0, 1, c + 17);
    @(negedge clk);
    rnd_in = 16'hA5A5;
    check("t1_busy_in_div", int'(busy), 1);
    wait_drain(40);
    req = '0;
    @(negedge clk);

    // Test 2: 0xFFFF mod 511 = 127.
    set_max(3, 511);
    rnd_in = 16'hFFFF;
    req    = 4'b1000;
    expect_grant(3, 127, cyc + 17);
    wait_drain(40);
    req = '0;
    @(negedge clk);

    // Test 3: all requesting, 0x1234 mod 100 = 60, grants 0,1,2,3,0 18 cycles apart.
    for (int k = 0; k < N_REQ; k++) set_max(k, 100);
    rnd_in = 16'h1234;
    req    = 4'b1111;
    c      = cyc;
    for (int k = 0; k < 5; k++) expect_grant(k % N_REQ, 60, c + 17 + 18 * k);
    wait_drain(120);
    req = '0;
    @(negedge clk);

    // Test 4: zero range forces zero result.
    set_max(1, 0);
    rnd_in = 16'hBEEF;
    req    = 4'b0010;
    expect_grant(1, 0, cyc + 17);
    wait_drain(40);
    req = '0;
    @(negedge clk);

    // Test 5: reset five cycles into DIV aborts the service and rewinds the pointer.
    set_max(2, 50);
    rnd_in = 16'h4321;
    req    = 4'b0100;
    repeat (6) @(negedge clk);
    check("t5_busy_before_rst", int'(busy), 1);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    reset = 1'b0;
    check("t5_busy",      int'(busy),      0);
    check("t5_out_valid", int'(out_valid), 0);
    check("t5_gnt",       int'(gnt),       0);
    repeat (25) @(negedge clk);
    for (int k = 0; k < N_REQ; k++) set_max(k, 7);
    rnd_in = 16'd100;
    req    = 4'b1111;
    expect_grant(0, 2, cyc + 17);
    wait_drain(40);
    req = '0;
    @(negedge clk);

    // Test 6: req dropped and range changed after capture; 255 mod 10 = 5.
    set_max(0, 10);
    rnd_in = 16'h00FF;
    req    = 4'b0001;
    expect_grant(0, 5, cyc + 17);
    @(negedge clk);
    req    = '0;
    rnd_in = 16'h7777;
    @(negedge clk);
    set_max(0, 3);
    wait_drain(40);
    repeat (3) @(negedge clk);
    check("hold_out_value", int'(out_value), 5);
    check("hold_out_id",    int'(out_id),    0);
    check("idle_busy",      int'(busy),      0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0d", 100000);
    $fatal(1, "watchdog expired");
  end

endmodule
